// File: rtl/rename_commit_queue_pkg.sv
// rename_commit_queue_pkg
// Shared types and constants for the rename commit queue.
//   tag_t / count_t : entry index and occupancy count for the default geometry
//   rcq_entry_t     : one queue slot {valid, done, name}
//   RCQ_ENTRY_RST   : slot value after reset
package rename_commit_queue_pkg;

    localparam int RCQ_DEPTH      = 4;
    localparam int RCQ_TAG_WIDTH  = 2;
    localparam int RCQ_NAME_WIDTH = 1;
    // The slot struct carries names up to this width; configured name_width
    // must not exceed it. Unused upper bits are constant zero.
    localparam int RCQ_NAME_MAX   = 16;

    typedef logic [RCQ_TAG_WIDTH-1:0] tag_t;
    typedef logic [RCQ_TAG_WIDTH:0]   count_t;

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic [RCQ_NAME_MAX-1:0] name;
    } rcq_entry_t;

    localparam rcq_entry_t RCQ_ENTRY_RST  = '0;
    localparam logic       RCQ_RST_ACTIVE = 1'b0;

endpackage

// File: rtl/rename_commit_queue_if.sv
// rcq_if
// Bundles the commit-queue handshake signals.
//   master : pipeline side (drives enqueue, done, commit permission)
//   slave  : queue side (returns ready, tag, free name/enable, count)
interface rcq_if
    import rename_commit_queue_pkg::*;
#(
    parameter int name_width = RCQ_NAME_WIDTH,
    parameter int tag_width  = RCQ_TAG_WIDTH
);
    logic [name_width-1:0] ENQ_NAME;
    logic                  ENQ_E;
    logic                  ENQ_READY;
    logic [tag_width-1:0]  ENQ_TAG;
    logic [tag_width-1:0]  DONE_TAG;
    logic                  DONE_E;
    logic                  COMMIT_E;
    logic [name_width-1:0] FREE_NAME;
    logic                  FREE_E;
    logic [tag_width:0]    COUNT;

    modport master (
        output ENQ_NAME, ENQ_E, DONE_TAG, DONE_E, COMMIT_E,
        input  ENQ_READY, ENQ_TAG, FREE_NAME, FREE_E, COUNT
    );

    modport slave (
        input  ENQ_NAME, ENQ_E, DONE_TAG, DONE_E, COMMIT_E,
        output ENQ_READY, ENQ_TAG, FREE_NAME, FREE_E, COUNT
    );
endinterface

// File: rtl/rename_commit_queue_ptr.sv
// rcq_ptr
// Wrapping pointer register; advances by one when inc is high and wraps
// modulo 2**width.
//   CLK, RST (async, active-low), inc : advance enable, ptr : current value
module rcq_ptr #(
    parameter int width = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [width-1:0] ptr
);
    logic [width-1:0] ptr_q;
    logic [width-1:0] ptr_d;

    always_comb begin
        ptr_d = inc ? ptr_q + width'(1) : ptr_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/rename_commit_queue.sv
// rename_commit_queue
// In-order commit queue behind the register renamer. Records allocated
// physical names in program order, marks them complete on writeback and
// hands them back to the renamer's free port strictly in allocation order,
// at most one per cycle.
// Ports:
//   CLK, RST (async, active-low)
//   bus (rcq_if.slave): ENQ_NAME/ENQ_E/ENQ_READY/ENQ_TAG enqueue,
//     DONE_TAG/DONE_E writeback, COMMIT_E retire permission,
//     FREE_NAME/FREE_E retire to renamer, COUNT occupancy.
// Build option: define RCQ_DONE_BYPASS_EN to let a writeback to the head
// entry retire it in the same cycle (adds a DONE -> FREE_E comb path).
module rename_commit_queue
    import rename_commit_queue_pkg::*;
#(
    parameter int name_width = RCQ_NAME_WIDTH,
    parameter int depth      = RCQ_DEPTH,
    parameter int tag_width  = RCQ_TAG_WIDTH
) (
    input  logic CLK,
    input  logic RST,
    rcq_if.slave bus
);
    localparam logic [tag_width:0] FULL = (tag_width + 1)'(depth);

    logic [tag_width-1:0] head;
    logic [tag_width-1:0] tail;
    logic [tag_width:0]   count_q;
    logic [tag_width:0]   count_d;
    rcq_entry_t           ent_q [depth];
    rcq_entry_t           ent_d [depth];
    rcq_entry_t           head_ent;
    logic                 enq_ready;
    logic                 enq_fire;
    logic                 done_fire;
    logic                 head_done;
    logic                 free_fire;
    logic                 unused_name_bits;

    assign head_ent = ent_q[head];
    assign unused_name_bits = ^head_ent.name;

    always_comb begin
        // Readiness comes from registered count only: a full queue never
        // accepts in the cycle it retires.
        enq_ready = (count_q != FULL);
        enq_fire  = bus.ENQ_E && enq_ready;
        done_fire = bus.DONE_E && ent_q[bus.DONE_TAG].valid;
`ifdef RCQ_DONE_BYPASS_EN
        head_done = head_ent.done || (bus.DONE_E && (bus.DONE_TAG == head));
`else
        head_done = head_ent.done;
`endif
        free_fire = bus.COMMIT_E && head_ent.valid && head_done;
    end

    always_comb begin
        for (int i = 0; i < depth; i++) ent_d[i] = ent_q[i];
        if (done_fire) ent_d[bus.DONE_TAG].done = 1'b1;
        // Tail slot is empty whenever enqueue fires, so a done aimed at it
        // was already rejected by done_fire.
        if (enq_fire) begin
            ent_d[tail].valid = 1'b1;
            ent_d[tail].done  = 1'b0;
            ent_d[tail].name  = RCQ_NAME_MAX'(bus.ENQ_NAME);
        end
        // Retire last so a same-cycle done on the head slot cannot survive.
        if (free_fire) ent_d[head] = RCQ_ENTRY_RST;
    end

    always_comb begin
        case ({enq_fire, free_fire})
            2'b10:   count_d = count_q + (tag_width + 1)'(1);
            2'b01:   count_d = count_q - (tag_width + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (RST == RCQ_RST_ACTIVE) begin
            count_q <= '0;
            for (int i = 0; i < depth; i++) ent_q[i] <= RCQ_ENTRY_RST;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < depth; i++) ent_q[i] <= ent_d[i];
        end
    end

    rcq_ptr #(.width(tag_width)) u_head (
        .CLK (CLK),
        .RST (RST),
        .inc (free_fire),
        .ptr (head)
    );

    rcq_ptr #(.width(tag_width)) u_tail (
        .CLK (CLK),
        .RST (RST),
        .inc (enq_fire),
        .ptr (tail)
    );

    assign bus.ENQ_READY = enq_ready;
    assign bus.ENQ_TAG   = tail;
    assign bus.COUNT     = count_q;
    assign bus.FREE_E    = free_fire;
    assign bus.FREE_NAME = free_fire ? head_ent.name[name_width-1:0] : '0;
endmodule
